// File: rtl/demux_lane_deserializer.sv
// demux_lane_deserializer
//   Sits after demux_1x4. On each valid sample it takes Y[S] as the next serial bit of
//   lane S and packs it into that lane's WORD_W-bit word, LSB first. Completed words wait
//   in their lane and go out one at a time through a valid/ready port. Lanes are served
//   round-robin.
//   The block also keeps two sticky flags. overflow[l] sets when lane l drops a bit.
//   sel_err sets when a valid sample drives a 1 on an unselected Y line.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   Y/S sample valid this cycle
//   S          in   lane select driving the demux
//   Y          in   demux outputs, Y[S] carries the data bit
//   out_valid  out  out_word/out_lane valid
//   out_ready  in   consumer accepts when out_valid & out_ready
//   out_lane   out  lane the word was assembled on
//   out_word   out  assembled word, first received bit in bit 0
//   overflow   out  sticky per lane: bit dropped while the lane word was pending
//   sel_err    out  sticky: valid sample with Y[j]=1 for some j != S
module demux_lane_deserializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        S,
    input  logic [3:0]        Y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_lane,
    output logic [WORD_W-1:0] out_word,
    output logic [3:0]        overflow,
    output logic              sel_err
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned IDX_W = $clog2(WORD_W);

    // Lane state: a count below WORD_W means the lane is collecting bits.
    // A count equal to WORD_W means the word is complete and waits for a grant.
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [WORD_W-1:0] sr_q  [4];
    logic [WORD_W-1:0] sr_d  [4];
    logic [3:0]        pending;

    logic [3:0]        ovf_q, ovf_d;
    logic              sel_err_q, sel_err_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_lane_q, out_lane_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;

    logic              out_free;
    logic              grant_vld;
    logic [1:0]        grant_lane;
    logic [1:0]        cand;

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            pending[l] = (cnt_q[l] == CNT_W'(WORD_W));
        end

        out_free = !out_valid_q || out_ready;

        // Search the lanes in the order ptr+1, ptr+2, ptr+3, ptr (all mod 4).
        grant_vld  = 1'b0;
        grant_lane = 2'd0;
        cand       = 2'd0;
        if (out_free) begin
            for (int k = 1; k <= 4; k++) begin
                cand = rr_ptr_q + 2'(k);
                if (!grant_vld && pending[cand]) begin
                    grant_vld  = 1'b1;
                    grant_lane = cand;
                end
            end
        end

        sel_err_d = sel_err_q | (in_valid && ((Y & ~(4'b0001 << S)) != 4'b0000));

        ovf_d = ovf_q;
        for (int l = 0; l < 4; l++) begin
            cnt_d[l] = cnt_q[l];
            sr_d[l]  = sr_q[l];
            if (grant_vld && (grant_lane == 2'(l))) begin
                // The grant empties the lane. A bit arriving on the same edge starts the
                // new word, so it is not counted as an overflow.
                cnt_d[l] = '0;
                sr_d[l]  = '0;
                if (in_valid && (S == 2'(l))) begin
                    sr_d[l][0] = Y[l];
                    cnt_d[l]   = CNT_W'(1);
                end
            end else if (pending[l]) begin
                if (in_valid && (S == 2'(l))) begin
                    ovf_d[l] = 1'b1;
                end
            end else if (in_valid && (S == 2'(l))) begin
                sr_d[l][cnt_q[l][IDX_W-1:0]] = Y[l];
                cnt_d[l]                     = cnt_q[l] + CNT_W'(1);
            end
        end

        out_valid_d = out_valid_q;
        out_lane_d  = out_lane_q;
        out_word_d  = out_word_q;
        rr_ptr_d    = rr_ptr_q;
        if (out_free) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_lane_d = grant_lane;
                out_word_d = sr_q[grant_lane];
                rr_ptr_d   = grant_lane;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 4; l++) begin
                cnt_q[l] <= '0;
                sr_q[l]  <= '0;
            end
            ovf_q       <= 4'b0000;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= 2'd3;
            out_valid_q <= 1'b0;
            out_lane_q  <= 2'd0;
            out_word_q  <= '0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                cnt_q[l] <= cnt_d[l];
                sr_q[l]  <= sr_d[l];
            end
            ovf_q       <= ovf_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_word_q  <= out_word_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_lane  = out_lane_q;
    assign out_word  = out_word_q;
    assign overflow  = ovf_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Directed bench for demux_lane_deserializer with WORD_W=4.
// The bench drives inputs 1 time unit after each rising edge and samples there too.
module tb_demux_lane_deserializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   S;
    logic [3:0]   Y;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_lane;
    logic [W-1:0] out_word;
    logic [3:0]   overflow;
    logic         sel_err;

    int errors = 0;
    int checks = 0;

    demux_lane_deserializer #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .S         (S),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_word  (out_word),
        .overflow  (overflow),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        S         = 2'd0;
        Y         = 4'b0000;
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Sends the first nbits bits of word to one lane, LSB first, with a clean Y.
    task automatic send_bits(input logic [1:0] lane, input logic [3:0] word, input int nbits);
        for (int r = 0; r < nbits; r++) begin
            in_valid = 1'b1;
            S        = lane;
            Y        = 4'(word[r]) << lane;
            step();
        end
        in_valid = 1'b0;
        Y        = 4'b0000;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_lane, out_word, overflow, sel_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got %b required %b",
                     {out_valid, out_lane, out_word, overflow, sel_err}, 12'h000);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready = 1'b1;
        send_bits(2'd0, 4'b1101, 4);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: out_valid got %b required 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd0, 4'b1101}) begin
            errors++;
            $display("FAIL single_word: got v=%b lane=%0d word=%b required v=1 lane=0 word=1101",
                     out_valid, out_lane, out_word);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_interleave();
        logic [3:0] wa;
        logic [3:0] wb;
        wa = 4'b0110;
        wb = 4'b0011;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            S        = (i % 2 == 0) ? 2'd1 : 2'd2;
            Y        = (i % 2 == 0) ? (4'(wa[i/2]) << 1) : (4'(wb[i/2]) << 2);
            step();
        end
        in_valid = 1'b0;
        Y        = 4'b0000;
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd1, 4'b0110}) begin
            errors++;
            $display("FAIL interleave_lane1: got v=%b lane=%0d word=%b required v=1 lane=1 word=0110",
                     out_valid, out_lane, out_word);
        end
        step();
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd2, 4'b0011}) begin
            errors++;
            $display("FAIL interleave_lane2: got v=%b lane=%0d word=%b required v=1 lane=2 word=0011",
                     out_valid, out_lane, out_word);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL interleave_drain: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send_bits(2'd3, 4'b0111, 4);
        step();
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd3, 4'b0111}) begin
            errors++;
            $display("FAIL bp_first: got v=%b lane=%0d word=%b required v=1 lane=3 word=0111",
                     out_valid, out_lane, out_word);
        end
        send_bits(2'd3, 4'b1010, 4);
        send_bits(2'd3, 4'b0011, 2);
        checks++;
        if ({out_valid, out_lane, out_word, overflow} !== {1'b1, 2'd3, 4'b0111, 4'b1000}) begin
            errors++;
            $display("FAIL bp_hold_overflow: got v=%b lane=%0d word=%b ovf=%b required 1 3 0111 1000",
                     out_valid, out_lane, out_word, overflow);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd3, 4'b1010}) begin
            errors++;
            $display("FAIL bp_second: got v=%b lane=%0d word=%b required v=1 lane=3 word=1010",
                     out_valid, out_lane, out_word);
        end
        step();
        checks++;
        if ({out_valid, overflow} !== {1'b0, 4'b1000}) begin
            errors++;
            $display("FAIL bp_drain: got v=%b ovf=%b required v=0 ovf=1000", out_valid, overflow);
        end
        send_bits(2'd3, 4'b0001, 4);
        step();
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd3, 4'b0001}) begin
            errors++;
            $display("FAIL bp_restart: got v=%b lane=%0d word=%b required v=1 lane=3 word=0001",
                     out_valid, out_lane, out_word);
        end
    endtask

    task automatic test_sel_err();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        S         = 2'd1;
        Y         = 4'b0110;
        step();
        in_valid = 1'b0;
        Y        = 4'b0000;
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: got %b required 1", sel_err);
        end
        send_bits(2'd1, 4'b0000, 3);
        step();
        checks++;
        if ({out_valid, out_lane, out_word, sel_err} !== {1'b1, 2'd1, 4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL sel_err_word: got v=%b lane=%0d word=%b err=%b required 1 1 0001 1",
                     out_valid, out_lane, out_word, sel_err);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] words [4];
        words[0] = 4'b1001;
        words[1] = 4'b0101;
        words[2] = 4'b1110;
        words[3] = 4'b0011;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            S        = 2'(i % 4);
            Y        = 4'(words[i % 4][i / 4]) << (i % 4);
            step();
        end
        in_valid  = 1'b0;
        Y         = 4'b0000;
        out_ready = 1'b1;
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd0, words[0]}) begin
            errors++;
            $display("FAIL rr_grant0: got v=%b lane=%0d word=%b required v=1 lane=0 word=%b",
                     out_valid, out_lane, out_word, words[0]);
        end
        for (int g = 1; g < 4; g++) begin
            step();
            checks++;
            if ({out_valid, out_lane, out_word} !== {1'b1, 2'(g), words[g]}) begin
                errors++;
                $display("FAIL rr_grant%0d: got v=%b lane=%0d word=%b required v=1 lane=%0d word=%b",
                         g, out_valid, out_lane, out_word, g, words[g]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        send_bits(2'd1, 4'b1111, 4);
        step();
        // Lane 2 gets three bits; the second one also drives Y[0] high.
        send_bits(2'd2, 4'b1111, 1);
        in_valid = 1'b1;
        S        = 2'd2;
        Y        = 4'b0101;
        step();
        send_bits(2'd2, 4'b1111, 1);
        checks++;
        if ({out_valid, sel_err} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset: got v=%b err=%b required 11", out_valid, sel_err);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_lane, out_word, overflow, sel_err} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: got %b required %b",
                     {out_valid, out_lane, out_word, overflow, sel_err}, 12'h000);
        end
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        send_bits(2'd2, 4'b0101, 3);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial: out_valid got %b required 0", out_valid);
        end
        send_bits(2'd2, 4'b0000, 1);
        step();
        checks++;
        if ({out_valid, out_lane, out_word} !== {1'b1, 2'd2, 4'b0101}) begin
            errors++;
            $display("FAIL reset_fresh_word: got v=%b lane=%0d word=%b required v=1 lane=2 word=0101",
                     out_valid, out_lane, out_word);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        S         = 2'd0;
        Y         = 4'b0000;
        out_ready = 1'b0;
        test_reset();
        test_single_word();
        test_interleave();
        test_backpressure();
        test_sel_err();
        test_round_robin();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
